// File: rtl/except_sched_pkg.sv
// ============================================================================
// Module : except_sched_pkg
// Purpose: Shared definitions for the exception/interrupt scheduler:
//          Cause.ExcCode values, exc_type_m bit positions, scheduler state
//          encoding, BadVAddr source selector and the EPC helper.
// Ports  : none (package)
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package except_sched_pkg;

  // exc_type_m flag positions
  localparam int EXC_W          = 9;
  localparam int EXC_BIT_INT    = 0;
  localparam int EXC_BIT_ADEL_F = 1;
  localparam int EXC_BIT_RI     = 2;
  localparam int EXC_BIT_OV     = 3;
  localparam int EXC_BIT_SYS    = 4;
  localparam int EXC_BIT_BP     = 5;
  localparam int EXC_BIT_ADES   = 6;
  localparam int EXC_BIT_ADEL_D = 7;
  localparam int EXC_BIT_ERET   = 8;

  // Cause.ExcCode values
  localparam logic [4:0] EXCCODE_INT  = 5'd0;
  localparam logic [4:0] EXCCODE_ADEL = 5'd4;
  localparam logic [4:0] EXCCODE_ADES = 5'd5;
  localparam logic [4:0] EXCCODE_SYS  = 5'd8;
  localparam logic [4:0] EXCCODE_BP   = 5'd9;
  localparam logic [4:0] EXCCODE_RI   = 5'd10;
  localparam logic [4:0] EXCCODE_OV   = 5'd12;

  // Scheduler state encoding
  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_DRAIN    = 2'd1;
  localparam logic [1:0] ST_COMMIT   = 2'd2;
  localparam logic [1:0] ST_REDIRECT = 2'd3;

  // Where BadVAddr comes from for the winning event
  typedef enum logic [1:0] {
    BADV_NONE = 2'd0,
    BADV_PC   = 2'd1,
    BADV_DATA = 2'd2
  } badv_src_e;

  // EPC points at the branch when the faulting instruction is in its delay
  // slot; 32-bit wraparound is intentional.
  function automatic logic [31:0] epc_of(input logic [31:0] pc, input logic bd);
    return bd ? (pc - 32'd4) : pc;
  endfunction

endpackage

`default_nettype wire

// File: rtl/except_sched_prio_enc.sv
// ============================================================================
// Module : exc_prio_enc
// Purpose: Combinational priority encoder selecting the single winning event
//          from a taken interrupt and the MEM-stage exception flags.
// Ports  : int_taken_i  interrupt accepted this cycle (highest priority)
//          exc_i        exc_type_m flags (bit 0 is not used)
//          exccode_o    Cause.ExcCode of the winner
//          is_eret_o    winner is ERET (only when nothing else is flagged)
//          badv_src_o   BadVAddr source of the winner
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module exc_prio_enc
  import except_sched_pkg::*;
(
  input  logic             int_taken_i,
  input  logic [EXC_W-1:0] exc_i,
  output logic [4:0]       exccode_o,
  output logic             is_eret_o,
  output badv_src_e        badv_src_o
);

  // The MEM-stage Int flag is superseded by int_taken_i.
  logic unused_int_flag;
  assign unused_int_flag = exc_i[EXC_BIT_INT];

  always_comb begin
    exccode_o  = EXCCODE_INT;
    is_eret_o  = 1'b0;
    badv_src_o = BADV_NONE;
    if (int_taken_i) begin
      exccode_o = EXCCODE_INT;
    end else if (exc_i[EXC_BIT_ADEL_F]) begin
      exccode_o  = EXCCODE_ADEL;
      badv_src_o = BADV_PC;
    end else if (exc_i[EXC_BIT_RI]) begin
      exccode_o = EXCCODE_RI;
    end else if (exc_i[EXC_BIT_OV]) begin
      exccode_o = EXCCODE_OV;
    end else if (exc_i[EXC_BIT_SYS]) begin
      exccode_o = EXCCODE_SYS;
    end else if (exc_i[EXC_BIT_BP]) begin
      exccode_o = EXCCODE_BP;
    end else if (exc_i[EXC_BIT_ADES]) begin
      exccode_o  = EXCCODE_ADES;
      badv_src_o = BADV_DATA;
    end else if (exc_i[EXC_BIT_ADEL_D]) begin
      exccode_o  = EXCCODE_ADEL;
      badv_src_o = BADV_DATA;
    end else if (exc_i[EXC_BIT_ERET]) begin
      is_eret_o = 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/except_sched.sv
// ============================================================================
// Module : except_sched
// Purpose: Exception/interrupt scheduler between MEM and CP0. Samples one
//          event in IDLE, drains an outstanding AXI data access, issues one
//          CP0 commit plus pipeline flush, then holds a PC redirect until the
//          fetch unit accepts it.
// Ports  : clock/reset                  clock, synchronous active-high reset
//          exc_type_m, pc_m, in_delay_slot_m, data_addr_m   MEM-stage event
//          int_pending, status_exl, epc_in                   CP0 state
//          stall_m, mem_busy, redirect_ready                 handshakes
//          busy                         scheduler not idle
//          cp0_*                        one-cycle CP0 commit bundle
//          flush                        one-cycle IF..MEM flush
//          redirect_valid, redirect_pc  held PC redirect
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module except_sched
  import except_sched_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = 32'hBFC00380
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [EXC_W-1:0] exc_type_m,
  input  logic [31:0]      pc_m,
  input  logic             in_delay_slot_m,
  input  logic [31:0]      data_addr_m,
  input  logic             int_pending,
  input  logic             status_exl,
  input  logic [31:0]      epc_in,
  input  logic             stall_m,
  input  logic             mem_busy,
  input  logic             redirect_ready,
  output logic             busy,
  output logic             cp0_we,
  output logic             cp0_epc_we,
  output logic [31:0]      cp0_epc,
  output logic             cp0_bd,
  output logic [4:0]       cp0_exccode,
  output logic             cp0_badv_we,
  output logic [31:0]      cp0_badvaddr,
  output logic             cp0_set_exl,
  output logic             cp0_clr_exl,
  output logic             flush,
  output logic             redirect_valid,
  output logic [31:0]      redirect_pc
);

  logic [1:0]  state_q, state_d;

  // Event context captured at the sample edge
  logic [31:0] pc_q;
  logic        bd_q;
  logic [31:0] daddr_q;
  logic [31:0] eret_pc_q;
  logic        exl_q;
  logic [4:0]  exccode_q;
  logic        is_eret_q;
  badv_src_e   badv_src_q;

  logic        int_taken;
  logic        sample;
  logic [4:0]  enc_exccode;
  logic        enc_is_eret;
  badv_src_e   enc_badv_src;

  // Bit 0 of exc_type_m carries no event; interrupts come from int_pending.
  assign int_taken = int_pending & ~status_exl;
  assign sample    = ~stall_m &
                     ((|exc_type_m[EXC_BIT_ERET:EXC_BIT_ADEL_F]) | int_taken);

  exc_prio_enc u_prio_enc (
    .int_taken_i (int_taken),
    .exc_i       (exc_type_m),
    .exccode_o   (enc_exccode),
    .is_eret_o   (enc_is_eret),
    .badv_src_o  (enc_badv_src)
  );

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Event context: only loaded on an IDLE sample, so inputs are ignored while
  // an episode is in flight.
  always_ff @(posedge clock) begin
    if (reset) begin
      pc_q       <= '0;
      bd_q       <= 1'b0;
      daddr_q    <= '0;
      eret_pc_q  <= '0;
      exl_q      <= 1'b0;
      exccode_q  <= '0;
      is_eret_q  <= 1'b0;
      badv_src_q <= BADV_NONE;
    end else if ((state_q == ST_IDLE) && sample) begin
      pc_q       <= pc_m;
      bd_q       <= in_delay_slot_m;
      daddr_q    <= data_addr_m;
      eret_pc_q  <= epc_in;
      exl_q      <= status_exl;
      exccode_q  <= enc_exccode;
      is_eret_q  <= enc_is_eret;
      badv_src_q <= enc_badv_src;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (sample) begin
          state_d = mem_busy ? ST_DRAIN : ST_COMMIT;
        end
      end
      ST_DRAIN: begin
        if (!mem_busy) begin
          state_d = ST_COMMIT;
        end
      end
      ST_COMMIT: begin
        state_d = ST_REDIRECT;
      end
      ST_REDIRECT: begin
        if (redirect_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Output logic: everything is zero outside the state that owns it.
  // --------------------------------------------------------------------------
  always_comb begin
    busy           = (state_q != ST_IDLE);
    cp0_we         = 1'b0;
    cp0_epc_we     = 1'b0;
    cp0_epc        = '0;
    cp0_bd         = 1'b0;
    cp0_exccode    = '0;
    cp0_badv_we    = 1'b0;
    cp0_badvaddr   = '0;
    cp0_set_exl    = 1'b0;
    cp0_clr_exl    = 1'b0;
    flush          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    case (state_q)
      ST_COMMIT: begin
        cp0_we = 1'b1;
        flush  = 1'b1;
        if (is_eret_q) begin
          cp0_clr_exl = 1'b1;
        end else begin
          cp0_set_exl = 1'b1;
          // A nested exception under EXL must not overwrite EPC.
          cp0_epc_we  = ~exl_q;
          cp0_epc     = epc_of(pc_q, bd_q);
          cp0_bd      = bd_q;
          cp0_exccode = exccode_q;
          cp0_badv_we = (badv_src_q != BADV_NONE);
          if (badv_src_q == BADV_PC) begin
            cp0_badvaddr = pc_q;
          end else if (badv_src_q == BADV_DATA) begin
            cp0_badvaddr = daddr_q;
          end
        end
      end
      ST_REDIRECT: begin
        redirect_valid = 1'b1;
        redirect_pc    = is_eret_q ? eret_pc_q : EXC_VECTOR;
      end
      default: begin
      end
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_except_sched.sv
`default_nettype none

module tb_except_sched;

  localparam logic [31:0] VEC = 32'hBFC00380;

  logic        clock;
  logic        reset;
  logic [8:0]  exc_type_m;
  logic [31:0] pc_m;
  logic        in_delay_slot_m;
  logic [31:0] data_addr_m;
  logic        int_pending;
  logic        status_exl;
  logic [31:0] epc_in;
  logic        stall_m;
  logic        mem_busy;
  logic        redirect_ready;
  logic        busy;
  logic        cp0_we;
  logic        cp0_epc_we;
  logic [31:0] cp0_epc;
  logic        cp0_bd;
  logic [4:0]  cp0_exccode;
  logic        cp0_badv_we;
  logic [31:0] cp0_badvaddr;
  logic        cp0_set_exl;
  logic        cp0_clr_exl;
  logic        flush;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  int n_chk  = 0;
  int n_pass = 0;

  // ExcCode by exc_type_m bit position (bit 0 and ERET carry no code)
  int code_tab [0:8] = '{0, 4, 10, 12, 8, 9, 5, 4, 0};

  except_sched #(.EXC_VECTOR(VEC)) dut (
    .clock           (clock),
    .reset           (reset),
    .exc_type_m      (exc_type_m),
    .pc_m            (pc_m),
    .in_delay_slot_m (in_delay_slot_m),
    .data_addr_m     (data_addr_m),
    .int_pending     (int_pending),
    .status_exl      (status_exl),
    .epc_in          (epc_in),
    .stall_m         (stall_m),
    .mem_busy        (mem_busy),
    .redirect_ready  (redirect_ready),
    .busy            (busy),
    .cp0_we          (cp0_we),
    .cp0_epc_we      (cp0_epc_we),
    .cp0_epc         (cp0_epc),
    .cp0_bd          (cp0_bd),
    .cp0_exccode     (cp0_exccode),
    .cp0_badv_we     (cp0_badv_we),
    .cp0_badvaddr    (cp0_badvaddr),
    .cp0_set_exl     (cp0_set_exl),
    .cp0_clr_exl     (cp0_clr_exl),
    .flush           (flush),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Reference: interrupt beats everything; then the lowest flagged bit 1..7;
  // ERET only when nothing else is flagged.
  function automatic void ref_model(input logic [8:0] exc, input logic intp,
                                    input logic exl, output logic eret,
                                    output logic [4:0] code, output int bsrc);
    eret = 1'b0;
    code = 5'd0;
    bsrc = 0;
    if (intp && !exl) return;
    for (int b = 1; b <= 7; b++) begin
      if (exc[b]) begin
        code = 5'(code_tab[b]);
        bsrc = (b == 1) ? 1 : ((b >= 6) ? 2 : 0);
        return;
      end
    end
    eret = exc[8];
  endfunction

  task automatic quiet();
    exc_type_m      = '0;
    int_pending     = 1'b0;
    status_exl      = 1'b0;
    stall_m         = 1'b0;
    mem_busy        = 1'b0;
    redirect_ready  = 1'b0;
    in_delay_slot_m = 1'b0;
  endtask

  task automatic scramble();
    exc_type_m      = 9'($urandom);
    int_pending     = 1'($urandom);
    status_exl      = 1'($urandom);
    pc_m            = $urandom;
    in_delay_slot_m = 1'($urandom);
    data_addr_m     = $urandom;
    epc_in          = $urandom;
    stall_m         = 1'($urandom);
  endtask

  // One episode, entered and left at a negedge. rst_at>0 asserts reset in
  // that cycle of the episode and checks the abort instead of the tail.
  task automatic run_ep(input string tag, input logic [8:0] exc, input logic intp,
                        input logic exl, input logic [31:0] pc, input logic bd,
                        input logic [31:0] addr, input logic [31:0] epc,
                        input int nbusy, input int rdy_delay, input int rst_at);
    logic        sampled, eret;
    logic [4:0]  code;
    int          bsrc, commit, rdy_cyc, flushes;
    logic [31:0] exp_epc, exp_rpc;
    exc_type_m = exc; int_pending = intp; status_exl = exl; pc_m = pc;
    in_delay_slot_m = bd; data_addr_m = addr; epc_in = epc; stall_m = 1'b0;
    mem_busy = (nbusy > 0); redirect_ready = 1'b0;
    sampled = (exc[8:1] != 0) || (intp && !exl);
    ref_model(exc, intp, exl, eret, code, bsrc);
    exp_epc = bd ? pc - 32'd4 : pc;
    exp_rpc = eret ? epc : VEC;
    commit  = (nbusy == 0) ? 1 : nbusy + 1;
    rdy_cyc = commit + 1 + rdy_delay;
    flushes = 0;
    chk({tag, ":idle_busy"}, 32'(busy), 32'd0);
    @(negedge clock);
    if (!sampled) begin
      chk({tag, ":no_sample"}, 32'(busy), 32'd0);
      quiet();
      return;
    end
    for (int c = 1; c <= rdy_cyc + 1; c++) begin
      if (c == rdy_cyc + 1) begin
        chk({tag, ":done_busy"}, 32'(busy), 32'd0);
        chk({tag, ":done_rv"}, 32'(redirect_valid), 32'd0);
        break;
      end
      flushes += int'(flush);
      if (c < commit) begin
        chk({tag, ":drain_busy"}, 32'(busy), 32'd1);
        chk({tag, ":drain_we"}, 32'(cp0_we), 32'd0);
        chk({tag, ":drain_rv"}, 32'(redirect_valid), 32'd0);
      end else if (c == commit) begin
        chk({tag, ":we"}, 32'(cp0_we), 32'd1);
        chk({tag, ":flush"}, 32'(flush), 32'd1);
        chk({tag, ":commit_rv"}, 32'(redirect_valid), 32'd0);
        chk({tag, ":set_exl"}, 32'(cp0_set_exl), 32'(!eret));
        chk({tag, ":clr_exl"}, 32'(cp0_clr_exl), 32'(eret));
        chk({tag, ":epc_we"}, 32'(cp0_epc_we), 32'(!eret && !exl));
        chk({tag, ":badv_we"}, 32'(cp0_badv_we), 32'(bsrc != 0));
        if (!eret) chk({tag, ":exccode"}, 32'(cp0_exccode), 32'(code));
        if (!eret && !exl) begin
          chk({tag, ":epc"}, cp0_epc, exp_epc);
          chk({tag, ":bd"}, 32'(cp0_bd), 32'(bd));
        end
        if (bsrc != 0) chk({tag, ":badvaddr"}, cp0_badvaddr, (bsrc == 1) ? pc : addr);
      end else begin
        chk({tag, ":rv"}, 32'(redirect_valid), 32'd1);
        chk({tag, ":rpc"}, redirect_pc, exp_rpc);
        chk({tag, ":redir_we"}, 32'(cp0_we), 32'd0);
      end
      if (rst_at != 0 && c == rst_at) begin
        reset = 1'b1;
        quiet();
        @(negedge clock);
        chk({tag, ":rst_busy"}, 32'(busy), 32'd0);
        chk({tag, ":rst_rv"}, 32'(redirect_valid), 32'd0);
        chk({tag, ":rst_we"}, 32'(cp0_we), 32'd0);
        chk({tag, ":rst_flush"}, 32'(flush), 32'd0);
        reset = 1'b0;
        return;
      end
      scramble();
      mem_busy       = (c < nbusy);
      redirect_ready = (c == rdy_cyc) ? 1'b1 : ((c <= commit) ? 1'($urandom) : 1'b0);
      @(negedge clock);
    end
    chk({tag, ":flush_once"}, 32'(flushes), 32'd1);
    quiet();
  endtask

  initial begin
    reset = 1'b1;
    pc_m = '0; data_addr_m = '0; epc_in = '0;
    quiet();
    repeat (2) @(negedge clock);
    chk("reset:busy", 32'(busy), 32'd0);
    chk("reset:we", 32'(cp0_we), 32'd0);
    chk("reset:rv", 32'(redirect_valid), 32'd0);
    chk("reset:rpc", redirect_pc, 32'd0);
    chk("reset:epc", cp0_epc, 32'd0);
    chk("reset:badv", cp0_badvaddr, 32'd0);
    chk("reset:flush", 32'(flush), 32'd0);
    reset = 1'b0;
    @(negedge clock);

    run_ep("sys",     9'h010, 1'b0, 1'b0, 32'hBFC01000, 1'b0, 32'h0, 32'h0, 0, 0, 0);
    run_ep("ades",    9'h040, 1'b0, 1'b0, 32'h80001008, 1'b1, 32'h80000003, 32'h0, 0, 1, 0);
    run_ep("int_ov",  9'h008, 1'b1, 1'b0, 32'h80003000, 1'b0, 32'h0, 32'h0, 3, 0, 0);
    run_ep("eret",    9'h100, 1'b0, 1'b1, 32'h80004000, 1'b0, 32'h0, 32'h80002000, 0, 4, 0);
    run_ep("ri_exl",  9'h004, 1'b1, 1'b1, 32'h80005000, 1'b0, 32'h0, 32'h0, 1, 0, 0);
    run_ep("bp_pc0",  9'h020, 1'b0, 1'b0, 32'h00000000, 1'b1, 32'h0, 32'h0, 0, 0, 0);
    run_ep("adelf",   9'h082, 1'b0, 1'b0, 32'h80006001, 1'b0, 32'h80007000, 32'h0, 2, 2, 0);
    run_ep("adeld",   9'h180, 1'b0, 1'b0, 32'h80006100, 1'b0, 32'h80007002, 32'h0, 0, 0, 0);
    run_ep("eret_sys",9'h110, 1'b0, 1'b0, 32'h80008000, 1'b0, 32'h0, 32'h80009000, 0, 0, 0);
    run_ep("idle_nop",9'h000, 1'b1, 1'b1, 32'h80008000, 1'b0, 32'h0, 32'h0, 0, 0, 0);

    // A stalled MEM stage must not be sampled
    exc_type_m = 9'h010; stall_m = 1'b1; int_pending = 1'b1;
    @(negedge clock);
    chk("stall:busy", 32'(busy), 32'd0);
    quiet();

    // Reset while in REDIRECT aborts the episode; the next event commits normally
    run_ep("rst_redir", 9'h010, 1'b0, 1'b0, 32'hBFC01000, 1'b0, 32'h0, 32'h0, 0, 3, 2);
    run_ep("after_rst", 9'h010, 1'b0, 1'b0, 32'hBFC01004, 1'b1, 32'h0, 32'h0, 0, 0, 0);

    for (int i = 0; i < 40; i++) begin
      logic [8:0] e;
      e = ($urandom_range(0, 1) == 0) ? (9'd1 << $urandom_range(1, 8)) : (9'($urandom) & 9'h1FE);
      run_ep("rand", e, 1'($urandom), 1'($urandom), $urandom, 1'($urandom), $urandom,
             $urandom, $urandom_range(0, 4), $urandom_range(0, 3), 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
